// File: rtl/hh_pkg.sv
// Shared Q8.8 types, Hodgkin-Huxley default constants, op indices and
// saturating add/sub helpers for the step sequencer.
package hh_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic signed [15:0] q8_8_t;

  localparam q8_8_t SAT_MAX = 16'sh7FFF;
  localparam q8_8_t SAT_MIN = 16'sh8000;

  localparam q8_8_t HH_G_NA     = 16'sh7800;
  localparam q8_8_t HH_G_K      = 16'sh2400;
  localparam q8_8_t HH_G_L      = 16'sh004D;
  localparam q8_8_t HH_E_NA     = 16'sh3200;
  localparam q8_8_t HH_E_K      = 16'shB300;
  localparam q8_8_t HH_E_L      = 16'shC99A;
  localparam q8_8_t HH_DT_OVER_C = 16'sh0003;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_M2   = 4'd1,
    OP_M3   = 4'd2,
    OP_GNA  = 4'd3,
    OP_GH   = 4'd4,
    OP_INA  = 4'd5,
    OP_N2   = 4'd6,
    OP_N4   = 4'd7,
    OP_GK   = 4'd8,
    OP_IK   = 4'd9,
    OP_IL   = 4'd10,
    OP_DV   = 4'd11
  } op_e;

  // Overflow shows up as the two top bits of the 17-bit result disagreeing.
  function automatic q8_8_t sat_add(input q8_8_t a, input q8_8_t b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? SAT_MIN : SAT_MAX;
    return s[15:0];
  endfunction

  function automatic q8_8_t sat_sub(input q8_8_t a, input q8_8_t b);
    logic [16:0] s;
    s = {a[15], a} - {b[15], b};
    if (s[16] != s[15]) return s[16] ? SAT_MIN : SAT_MAX;
    return s[15:0];
  endfunction

endpackage

// File: rtl/hh_fxp_mul.sv
// Pipelined signed Q8.8 multiplier: full product, floor shift by FRAC_BITS,
// saturate to 16 bits; result appears MUL_LAT cycles after the operands.
module hh_fxp_mul
  import hh_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  q8_8_t a,
  input  q8_8_t b,
  output q8_8_t p
);

  logic signed [31:0] prod;
  logic signed [31:0] shifted;
  q8_8_t              sat_p;
  q8_8_t              pipe [MUL_LAT];

  // The shifted value fits in 16 bits only when bits 31..15 are all equal.
  always_comb begin
    prod    = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    shifted = prod >>> FRAC_BITS;
    if ((&shifted[31:15]) || ~(|shifted[31:15])) sat_p = shifted[15:0];
    else                                          sat_p = shifted[31] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= sat_p;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[MUL_LAT-1];

endmodule

// File: rtl/hh_step_sequencer.sv
// Sequences one Hodgkin-Huxley integration step (Na, K, leak currents and
// membrane update) through a single shared pipelined Q8.8 multiplier.
module hh_step_sequencer
  import hh_pkg::*;
#(
  parameter int    MUL_LAT   = 2,
  parameter q8_8_t G_NA      = HH_G_NA,
  parameter q8_8_t G_K       = HH_G_K,
  parameter q8_8_t G_L       = HH_G_L,
  parameter q8_8_t E_NA      = HH_E_NA,
  parameter q8_8_t E_K       = HH_E_K,
  parameter q8_8_t E_L       = HH_E_L,
  parameter q8_8_t DT_OVER_C = HH_DT_OVER_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] v_in,
  input  logic [15:0] m_in,
  input  logic [15:0] h_in,
  input  logic [15:0] n_in,
  input  logic [15:0] i_ext,
  output logic        busy,
  output logic        done,
  output logic [15:0] v_out,
  output logic [15:0] i_na,
  output logic [15:0] i_k,
  output logic [15:0] i_l
);

  localparam int PW = $clog2(MUL_LAT + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(MUL_LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OP,
    ST_FINAL
  } state_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          result_strobe;

  q8_8_t v_q, m_q, h_q, n_q, iext_q;
  q8_8_t dna_q, dk_q, dl_q;
  q8_8_t m2_q, m3_q, ga_q, gb_q, ina_q;
  q8_8_t n2_q, n4_q, gc_q, ik_q, il_q, dv_q;
  q8_8_t acc;
  q8_8_t mul_a, mul_b, mul_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      phase_q <= phase_d;
    end
  end

  // Each op is one issue cycle followed by MUL_LAT wait cycles (phase counter).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_OP;
        op_d    = OP_M2;
        phase_d = '0;
      end
      ST_OP: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (op_q == OP_DV) begin
            state_d = ST_FINAL;
            op_d    = OP_NONE;
          end else begin
            op_d = op_e'(op_q + 4'd1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_FINAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign result_strobe = (state_q == ST_OP) && (phase_q == LAST_PHASE);
  assign busy          = (state_q != ST_IDLE);

  // Membrane drive, built from the three currents in a fixed saturating order.
  always_comb begin
    acc = sat_sub(iext_q, ina_q);
    acc = sat_sub(acc, ik_q);
    acc = sat_sub(acc, il_q);
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (op_q)
      OP_M2:   begin mul_a = m_q;       mul_b = m_q;   end
      OP_M3:   begin mul_a = m2_q;      mul_b = m_q;   end
      OP_GNA:  begin mul_a = G_NA;      mul_b = m3_q;  end
      OP_GH:   begin mul_a = ga_q;      mul_b = h_q;   end
      OP_INA:  begin mul_a = gb_q;      mul_b = dna_q; end
      OP_N2:   begin mul_a = n_q;       mul_b = n_q;   end
      OP_N4:   begin mul_a = n2_q;      mul_b = n2_q;  end
      OP_GK:   begin mul_a = G_K;       mul_b = n4_q;  end
      OP_IK:   begin mul_a = gc_q;      mul_b = dk_q;  end
      OP_IL:   begin mul_a = G_L;       mul_b = dl_q;  end
      OP_DV:   begin mul_a = DT_OVER_C; mul_b = acc;   end
      default: begin mul_a = '0;        mul_b = '0;    end
    endcase
  end

  hh_fxp_mul #(
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .a  (mul_a),
    .b  (mul_b),
    .p  (mul_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0; m_q   <= '0; h_q  <= '0; n_q  <= '0; iext_q <= '0;
      dna_q  <= '0; dk_q  <= '0; dl_q <= '0;
      m2_q   <= '0; m3_q  <= '0; ga_q <= '0; gb_q <= '0; ina_q  <= '0;
      n2_q   <= '0; n4_q  <= '0; gc_q <= '0; ik_q <= '0; il_q   <= '0;
      dv_q   <= '0;
      v_out  <= '0;
      i_na   <= '0;
      i_k    <= '0;
      i_l    <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_q == ST_FINAL);

      if (state_q == ST_LOAD) begin
        v_q    <= v_in;
        m_q    <= m_in;
        h_q    <= h_in;
        n_q    <= n_in;
        iext_q <= i_ext;
        dna_q  <= sat_sub(v_in, E_NA);
        dk_q   <= sat_sub(v_in, E_K);
        dl_q   <= sat_sub(v_in, E_L);
      end

      if (result_strobe) begin
        case (op_q)
          OP_M2:   m2_q  <= mul_p;
          OP_M3:   m3_q  <= mul_p;
          OP_GNA:  ga_q  <= mul_p;
          OP_GH:   gb_q  <= mul_p;
          OP_INA:  ina_q <= mul_p;
          OP_N2:   n2_q  <= mul_p;
          OP_N4:   n4_q  <= mul_p;
          OP_GK:   gc_q  <= mul_p;
          OP_IK:   ik_q  <= mul_p;
          OP_IL:   il_q  <= mul_p;
          OP_DV:   dv_q  <= mul_p;
          default: ;
        endcase
      end

      if (state_q == ST_FINAL) begin
        v_out <= sat_add(v_q, dv_q);
        i_na  <= ina_q;
        i_k   <= ik_q;
        i_l   <= il_q;
      end
    end
  end

endmodule

// File: tb/tb_hh_step_sequencer.sv
// Scoreboard bench for hh_step_sequencer: stimulus pushes expected results
// from an integer reference model; a done-triggered monitor pops and compares.
module tb_hh_step_sequencer;

  localparam int MUL_LAT = 2;
  localparam int LAT     = 2 + 11 * (MUL_LAT + 1);
  localparam int PERIOD  = LAT + 1;

  localparam int G_NA = 30720;
  localparam int G_K  = 9216;
  localparam int G_L  = 77;
  localparam int E_NA = 12800;
  localparam int E_K  = -19712;
  localparam int E_L  = -13926;
  localparam int DT   = 3;

  typedef struct {
    logic [15:0] v_out;
    logic [15:0] i_na;
    logic [15:0] i_k;
    logic [15:0] i_l;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] v_in = '0, m_in = '0, h_in = '0, n_in = '0, i_ext = '0;
  logic        busy, done;
  logic [15:0] v_out, i_na, i_k, i_l;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hh_step_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .v_in (v_in),
    .m_in (m_in),
    .h_in (h_in),
    .n_in (n_in),
    .i_ext(i_ext),
    .busy (busy),
    .done (done),
    .v_out(v_out),
    .i_na (i_na),
    .i_k  (i_k),
    .i_l  (i_l)
  );

  function automatic int satq(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int mulq(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return satq(p >>> 8);
  endfunction

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  // Step result derived directly from the Q8.8 arithmetic rules.
  function automatic exp_t refStep(input logic [15:0] v16, m16, h16, n16, i16);
    int v, m, h, n, ie, ina, n4, ik, il, acc, dv;
    exp_t e;
    v  = s16(v16); m = s16(m16); h = s16(h16); n = s16(n16); ie = s16(i16);
    ina = mulq(mulq(mulq(G_NA, mulq(mulq(m, m), m)), h), satq(v - E_NA));
    n4  = mulq(mulq(n, n), mulq(n, n));
    ik  = mulq(mulq(G_K, n4), satq(v - E_K));
    il  = mulq(G_L, satq(v - E_L));
    acc = satq(satq(satq(ie - ina) - ik) - il);
    dv  = mulq(DT, acc);
    e.v_out    = 16'(satq(v + dv));
    e.i_na     = 16'(ina);
    e.i_k      = 16'(ik);
    e.i_l      = 16'(il);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("done_latency", cyc, e.done_cyc);
        checkOutput("v_out", v_out, e.v_out);
        checkOutput("i_na", i_na, e.i_na);
        checkOutput("i_k", i_k, e.i_k);
        checkOutput("i_l", i_l, e.i_l);
        checkOutput("busy_in_done", busy, 0);
      end
    end
  end

  task automatic waitIdle();
    int budget = 0;
    while (busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, m, h, n, ie, input bit push,
                               input bit fixed, input logic [15:0] fv, fna, fk, fl);
    exp_t e;
    @(negedge clk);
    waitIdle();
    v_in = v; m_in = m; h_in = h; n_in = n; i_ext = ie;
    start = 1'b1;
    if (push) begin
      e = refStep(v, m, h, n, ie);
      if (fixed) begin
        e.v_out = fv; e.i_na = fna; e.i_k = fk; e.i_l = fl;
      end
      e.done_cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    v_in  = 16'($urandom); m_in = 16'($urandom); h_in = 16'($urandom);
    n_in  = 16'($urandom); i_ext = 16'($urandom);
  endtask

  function automatic logic [15:0] randGate();
    return 16'($urandom_range(0, 256));
  endfunction

  initial begin
    int   e0;
    int   budget;
    logic [15:0] hv, hm, hh, hn, hi;

    // Reset held with start asserted: nothing may move.
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
    end
    checkOutput("rst_v_out", v_out, 0);
    checkOutput("rst_i_na", i_na, 0);
    checkOutput("rst_i_k", i_k, 0);
    checkOutput("rst_i_l", i_l, 0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);

    applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1,
                  16'hFFCE, 16'h0000, 16'h0000, 16'h105C);
    applyStimulus(16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1, 1,
                  16'h014E, 16'h8000, 16'h0000, 16'h105C);
    applyStimulus(16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1, 0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Extra start pulse while busy must be dropped.
    repeat (5) @(negedge clk);
    checkOutput("busy_mid_step", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high: accepted in each done cycle, one step every PERIOD.
    @(negedge clk);
    waitIdle();
    hv = 16'($urandom_range(0, 16'h1800)) - 16'h0C00;
    hm = randGate(); hh = randGate(); hn = randGate(); hi = 16'($urandom);
    v_in = hv; m_in = hm; h_in = hh; n_in = hn; i_ext = hi;
    start = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e = refStep(hv, hm, hh, hn, hi);
      e.done_cyc = e0 + k * PERIOD + LAT;
      sb.push_back(e);
    end
    while (cyc < e0 + 2 * PERIOD + 1) @(negedge clk);
    start = 1'b0;

    for (int t = 0; t < 8; t++) begin
      logic [15:0] rv;
      rv = (t % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1800)) - 16'h0C00;
      applyStimulus(rv, randGate(), randGate(), randGate(), 16'($urandom), 1, 0,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000);
    end

    // Abort a step with reset partway through.
    applyStimulus(16'h0A00, 16'h0080, 16'h00C0, 16'h0060, 16'h0500, 0, 0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_v_out", v_out, 0);
    checkOutput("abort_i_na", i_na, 0);
    checkOutput("abort_i_k", i_k, 0);
    checkOutput("abort_i_l", i_l, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1,
                  16'hFFCE, 16'h0000, 16'h0000, 16'h105C);

    budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    repeat (PERIOD) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
